// File: rtl/alarm_beeper_if.sv
// Control/indicator bundle between the alarm FSM and the beeper.
interface alarm_beeper_if;
    logic start;
    logic stop;
    logic repeat_en;
    logic buzz;
    logic led;
    logic busy;
    logic done;

    modport master (
        output start, stop, repeat_en,
        input  buzz, led, busy, done
    );

    modport slave (
        input  start, stop, repeat_en,
        output buzz, led, busy, done
    );
endinterface

// File: rtl/alarm_beeper.sv
// Turns start/stop event pulses into a timed beep/gap burst on the buzzer and LED.
module alarm_beeper #(
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned ON_TICKS  = 25,
    parameter int unsigned OFF_TICKS = 25,
    parameter int unsigned BEEPS     = 4,
    parameter int unsigned TONE_DIV  = 25000
) (
    input  logic           clk,
    input  logic           rst,
    alarm_beeper_if.slave  bus
);

    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int unsigned BEEP_W = $clog2(BEEPS + 1);
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [PRE_W-1:0]    pre_cnt, pre_n;
    logic [PH_W-1:0]     phase_cnt, phase_n;
    logic [BEEP_W-1:0]   beep_cnt, beep_n;
    logic [TONE_W-1:0]   tone_cnt, tone_n;
    logic                buzz_q, buzz_n;
    logic                led_q, led_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                tick;
    logic                tone_wrap;

    assign tick      = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign tone_wrap = (tone_cnt == TONE_W'(TONE_DIV - 1));

    // State and counter registers; all outputs are flops as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            phase_cnt <= '0;
            beep_cnt  <= '0;
            tone_cnt  <= '0;
            buzz_q    <= 1'b0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            pre_cnt   <= pre_n;
            phase_cnt <= phase_n;
            beep_cnt  <= beep_n;
            tone_cnt  <= tone_n;
            buzz_q    <= buzz_n;
            led_q     <= led_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    // Next-state, counter and output decode; stop always wins over a phase end.
    always_comb begin
        state_n = state;
        pre_n   = pre_cnt;
        phase_n = phase_cnt;
        beep_n  = beep_cnt;
        tone_n  = tone_cnt;
        buzz_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                pre_n   = '0;
                phase_n = '0;
                tone_n  = '0;
                if (bus.start && !bus.stop) begin
                    state_n = ON;
                    beep_n  = '0;
                end
            end

            ON: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    pre_n   = '0;
                    phase_n = '0;
                    tone_n  = '0;
                end else begin
                    pre_n = tick ? '0 : pre_cnt + 1'b1;
                    if (tick && (phase_cnt == PH_W'(ON_TICKS - 1))) begin
                        state_n = OFF;
                        phase_n = '0;
                        tone_n  = '0;
                        // Saturate so indefinite repeat never wraps the count.
                        beep_n  = (beep_cnt == BEEP_W'(BEEPS)) ? beep_cnt : beep_cnt + 1'b1;
                    end else begin
                        if (tick) begin
                            phase_n = phase_cnt + 1'b1;
                        end
                        tone_n = tone_wrap ? '0 : tone_cnt + 1'b1;
                        buzz_n = tone_wrap ? ~buzz_q : buzz_q;
                    end
                end
            end

            OFF: begin
                if (bus.stop) begin
                    state_n = IDLE;
                    pre_n   = '0;
                    phase_n = '0;
                end else begin
                    pre_n = tick ? '0 : pre_cnt + 1'b1;
                    if (tick && (phase_cnt == PH_W'(OFF_TICKS - 1))) begin
                        phase_n = '0;
                        tone_n  = '0;
                        if ((beep_cnt == BEEP_W'(BEEPS)) && !bus.repeat_en) begin
                            state_n = IDLE;
                            pre_n   = '0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ON;
                        end
                    end else if (tick) begin
                        phase_n = phase_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                pre_n   = '0;
                phase_n = '0;
                tone_n  = '0;
            end
        endcase

        led_n  = (state_n == ON);
        busy_n = (state_n != IDLE);
    end

    assign bus.buzz = buzz_q;
    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Directed scoreboard bench for alarm_beeper with a small, fast parameter set.
module tb_alarm_beeper;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned ON_TICKS  = 2;
    localparam int unsigned OFF_TICKS = 3;
    localparam int unsigned BEEPS     = 2;
    localparam int unsigned TONE_DIV  = 2;

    localparam int ON_LEN = ON_TICKS * TICK_DIV;
    localparam int PERIOD = (ON_TICKS + OFF_TICKS) * TICK_DIV;

    typedef struct {
        logic [3:0] v;      // {buzz, led, busy, done}
        string      tag;
        int         idx;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    alarm_beeper_if bus ();

    alarm_beeper #(
        .TICK_DIV  (TICK_DIV),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .BEEPS     (BEEPS),
        .TONE_DIV  (TONE_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs i cycles after the start edge of an nb-beep burst.
    function automatic logic [3:0] burst_vec(input int i, input int nb);
        int p;
        p = i % PERIOD;
        if (i >= nb * PERIOD) begin
            return (i == nb * PERIOD) ? 4'b0001 : 4'b0000;
        end
        if (p < ON_LEN) begin
            return {1'((p / TONE_DIV) % 2), 1'b1, 1'b1, 1'b0};
        end
        return 4'b0010;
    endfunction

    task automatic push_range(input string tag, input int nb, input int from, input int to);
        exp_t e;
        for (int i = from; i < to; i++) begin
            e.v   = burst_vec(i, nb);
            e.tag = tag;
            e.idx = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.v   = 4'b0000;
            e.tag = tag;
            e.idx = i;
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_now();
        exp_t       e;
        logic [3:0] obs;
        obs = {bus.buzz, bus.led, bus.busy, bus.done};
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed buzz/led/busy/done=%b required an expectation", obs);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (obs === e.v) else begin
                miscompares++;
                $error("FAIL %s[%0d]: observed buzz/led/busy/done=%b required %b", e.tag, e.idx, obs, e.v);
            end
        end
    endtask

    // Runs n clock cycles; pulses start at s_a/s_b and stop at sp (relative cycle, -1 = none).
    task automatic run(input int n, input int s_a, input int s_b, input int sp);
        for (int i = 0; i < n; i++) begin
            if (i == s_a || i == s_b) bus.start = 1'b1;
            if (i == sp) bus.stop = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            chk_now();
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.repeat_en = 1'b0;

        // Reset values.
        #12;
        push_idle("reset", 1);
        chk_now();
        rst = 1'b0;

        // Stop while idle has no effect.
        push_idle("stop_idle", 3);
        run(3, -1, -1, 1);

        // Basic burst with an ignored start while busy.
        push_range("basic", 2, 0, 41);
        run(41, 0, 5, -1);

        // Start on the done cycle is accepted; another ignored busy start.
        push_range("restart", 2, 0, 43);
        run(43, 0, 10, -1);

        // Start and stop together in idle: stays idle.
        push_idle("start_stop_idle", 5);
        run(5, 0, -1, 0);

        // Abort mid-OFF with start and stop coincident while busy.
        push_range("abort", 2, 0, 15);
        push_idle("abort_idle", 10);
        run(25, 0, 15, 15);

        // Full burst after an abort.
        push_range("after_abort", 2, 0, 43);
        run(43, 0, -1, -1);

        // Stop on the final OFF->IDLE edge suppresses done.
        push_range("stop_final", 2, 0, 40);
        push_idle("stop_final_idle", 5);
        run(45, 0, -1, 40);

        // Indefinite repeat, then drop repeat_en inside the 7th beep.
        bus.repeat_en = 1'b1;
        push_range("repeat", 7, 0, 123);
        run(123, 0, -1, -1);
        bus.repeat_en = 1'b0;
        push_range("repeat_drop", 7, 123, 143);
        run(20, -1, -1, -1);

        // Asynchronous reset between clock edges while buzzing.
        push_range("rst_on", 2, 0, 4);
        run(4, 0, -1, -1);
        #2;
        rst = 1'b1;
        #1;
        push_idle("rst_async", 1);
        chk_now();
        #2;
        rst = 1'b0;
        push_idle("rst_after", 6);
        run(6, -1, -1, -1);

        // Clean burst after reset recovery.
        push_range("final", 2, 0, 43);
        run(43, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alarm_beeper.md
Name: alarm_beeper

Overview:
- Output-side counterpart of the push-button input conditioning chain.
- Converts single-cycle event pulses from the alarm control logic (alarm match, snooze expiry) into timed, human-perceivable outputs.
- Produces a buzzer tone square wave and an LED indicator in a beep/gap pattern, built from a clock prescaler, a phase counter and a beep counter.
- Sits between the alarm FSM and the board buzzer/LED pins.

Parameters:
TICK_DIV, 250000, clk cycles per pattern tick; >=2
ON_TICKS, 25, ticks per beep (sound) phase; >=1
OFF_TICKS, 25, ticks per gap (silence) phase; >=1
BEEPS, 4, beeps per burst when repeat_en=0; >=1
TONE_DIV, 25000, clk cycles per buzz half-period; >=1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; begins a burst when idle
stop  input  1  single-cycle pulse; aborts any burst (snooze/dismiss)
repeat_en  input  1  level; 1 = beep indefinitely until stop
buzz  output  1  tone square wave during beep phase, else 0
led  output  1  high during beep phase, else 0
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse on normal burst completion

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high (rst). Reset forces state=IDLE and clears all counters; buzz=0, led=0, busy=0, done=0.
- States:
  - IDLE -> ON on start=1 and stop=0.
  - ON -> OFF after ON_TICKS ticks.
  - OFF -> ON after OFF_TICKS ticks if beeps remain or repeat_en=1.
  - OFF -> IDLE otherwise.
  - ON/OFF -> IDLE on stop=1.
- Timing:
  - start sampled at edge k: state=ON from edge k. busy=1 and led=1 are visible in the cycle following edge k; there is no extra pipeline stage.
  - The prescaler is cleared on entry to ON from IDLE and on stop. It counts 0..TICK_DIV-1 and emits a tick when at TICK_DIV-1.
  - The phase counter clears at every state change.
  - ON lasts exactly ON_TICKS*TICK_DIV cycles; OFF lasts exactly OFF_TICKS*TICK_DIV cycles.
- Beep counting:
  - Counter width is clog2(BEEPS+1). It is cleared on IDLE->ON and incremented on each ON->OFF.
  - At the end of OFF: if count==BEEPS and repeat_en=0, go to IDLE.
  - repeat_en is sampled only at the end of each OFF phase. With repeat_en=1 the count saturates at BEEPS (no wrap).
- Tone:
  - The tone counter and buzz are cleared on every entry to ON.
  - buzz is 0 in the first ON cycle and toggles every TONE_DIV cycles while in ON.
  - buzz is forced to 0 in OFF and IDLE.
- led = (state==ON). busy = (state!=IDLE). All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.
- done: high for exactly the first IDLE cycle after OFF->IDLE via normal completion. It is never asserted on stop-abort or reset.
- Boundary and simultaneous-event rules:
  - start while busy: ignored (no restart, no count change).
  - start and stop in the same cycle in IDLE: stop wins, remain IDLE.
  - start and stop in the same cycle while busy: abort to IDLE.
  - stop in IDLE: no effect.
  - stop on the same edge as the final OFF->IDLE: abort takes priority, done=0.
  - start in the same cycle that done is high: accepted, new burst begins.
  - rst mid-burst: immediate return to reset values regardless of clk.

Test Plan (TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, BEEPS=2, TONE_DIV=2):
- Basic burst: pulse start at cycle 10 -> led=1 for cycles 11-18, 0 for 19-30, 1 for 31-38, 0 for 39-50; busy=1 for 11-50; done=1 at cycle 51 only; busy=0 at 51.
- Tone: during the first ON (cycles 11-18), buzz = 0,0,1,1,0,0,1,1; buzz=0 throughout OFF and after done.
- Abort: start at 10, stop at 25 -> busy/led/buzz=0 from cycle 26; done never asserted; a later start at 40 gives the full 40-cycle burst again.
- Repeat: repeat_en=1, start at 10 -> more than 5 ON phases observed with period 20 cycles and no done. Drop repeat_en mid-ON -> burst ends at the end of the current OFF with a done pulse.
- Collisions:
  - start pulses at 15 and 20 while busy -> no timing change.
  - start and stop in the same cycle in IDLE -> stays idle.
  - stop coincident with the final OFF->IDLE edge -> done=0.
- Async reset: assert rst mid-ON, between clk edges -> buzz/led/busy drop to 0 immediately. After release, idle until the next start.
